// File: rtl/bcd_sub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_sub_arbiter
// Purpose  : Round-robin arbiter and sequencer sharing one external pipelined
//            BCD subtract datapath among R requesters. Each issued operation
//            is tagged with its requester id, tracked through the datapath
//            latency and captured into an in-order first-word-fall-through
//            result FIFO. Credit control (in-flight tags + FIFO occupancy
//            never exceeding DEPTH) guarantees no result is ever dropped.
// Ports    : clk, rst             clock, asynchronous active-high reset
//            req[R]               per-requester request (operands held stable)
//            a_i, b_i [R*N*4]     packed operands, requester k at [k*N*4 +: N*4]
//            gnt[R]               one-hot combinational accept
//            sub_a, sub_b [N*4]   registered operands to the datapath
//            sub_o [N*4], sub_sgn datapath magnitude / sign (LAT cycles later)
//            res_valid/res_ready  result handshake (FIFO head)
//            res_id, res_o, res_sgn, res_err  head result fields
//            busy                 any tag in flight or any FIFO entry
// Options  : BCDSUB_ARB_DIGCHK_EN - flag operands containing nibbles > 9;
//            such operations still flow in order but return res_err=1 with a
//            zero result. Undefined: res_err is constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_sub_arbiter #(
    parameter int N     = 25,
    parameter int R     = 4,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R-1:0]         req,
    input  logic [R*N*4-1:0]     a_i,
    input  logic [R*N*4-1:0]     b_i,
    output logic [R-1:0]         gnt,
    output logic [N*4-1:0]       sub_a,
    output logic [N*4-1:0]       sub_b,
    input  logic [N*4-1:0]       sub_o,
    input  logic                 sub_sgn,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [$clog2(R)-1:0] res_id,
    output logic [N*4-1:0]       res_o,
    output logic                 res_sgn,
    output logic                 res_err,
    output logic                 busy
);

    localparam int c_W   = N * 4;
    localparam int c_IDW = $clog2(R);
    localparam int c_CW  = $clog2(DEPTH + 1);
    localparam int c_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // Arbitration and credit
    // ------------------------------------------------------------------
    logic [c_IDW-1:0] r_ptr;
    logic [c_CW-1:0]  r_out;     // in-flight tags + FIFO entries
    logic [c_IDW-1:0] w_sel;
    logic             w_issue;
    logic             w_pop;
    logic             w_err;
    int               w_idx;

    always_comb begin
        w_issue = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        gnt     = '0;
        for (int i = 0; i < R; i++) begin
            w_idx = (int'(r_ptr) + i) % R;
            if (!w_issue && req[w_idx]) begin
                w_issue = 1'b1;
                w_sel   = c_IDW'(w_idx);
            end
        end
        // r_out only drops on the edge after a pop, so a same-cycle pop
        // cannot be spent on a new issue.
        w_issue = w_issue & (r_out < c_CW'(DEPTH)) & ~rst;
        if (w_issue) begin
            gnt[w_sel] = 1'b1;
        end
    end

    logic [c_W-1:0] w_a_sel;
    logic [c_W-1:0] w_b_sel;
    assign w_a_sel = a_i[w_sel*c_W +: c_W];
    assign w_b_sel = b_i[w_sel*c_W +: c_W];

`ifdef BCDSUB_ARB_DIGCHK_EN
    function automatic logic has_bad_digit(input logic [c_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < N; d++) begin
            if (v[d*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction
    assign w_err = has_bad_digit(w_a_sel) | has_bad_digit(w_b_sel);
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            sub_a <= '0;
            sub_b <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_sel == c_IDW'(R - 1)) ? '0 : w_sel + c_IDW'(1);
            // Bad operands are replaced by zero so the datapath never sees
            // them; the tag's err bit overrides the returned result anyway.
            sub_a <= w_err ? '0 : w_a_sel;
            sub_b <= w_err ? '0 : w_b_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_out <= r_out + c_CW'(1);
                2'b01:   r_out <= r_out - c_CW'(1);
                default: r_out <= r_out;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag pipe: stage j is valid in cycle t+1+j, so stage LAT lines up
    // with the datapath output of the operands issued at cycle t.
    // ------------------------------------------------------------------
    logic [LAT:0]                  r_tv;
    logic [LAT:0]                  r_terr;
    logic [LAT:0][c_IDW-1:0]       r_tid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tv   <= '0;
            r_terr <= '0;
            r_tid  <= '0;
        end else begin
            r_tv[0]   <= w_issue;
            r_terr[0] <= w_err;
            r_tid[0]  <= w_sel;
            for (int j = 1; j <= LAT; j++) begin
                r_tv[j]   <= r_tv[j-1];
                r_terr[j] <= r_terr[j-1];
                r_tid[j]  <= r_tid[j-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [c_W-1:0]   r_mem_o   [DEPTH];
    logic [c_IDW-1:0] r_mem_id  [DEPTH];
    logic             r_mem_sgn [DEPTH];
    logic             r_mem_err [DEPTH];
    logic [c_AW-1:0]  r_wr;
    logic [c_AW-1:0]  r_rd;
    logic [c_CW-1:0]  r_cnt;
    logic             w_push;

    assign w_push = r_tv[LAT];
    assign w_pop  = res_valid & res_ready;

    function automatic logic [c_AW-1:0] ptr_next(input logic [c_AW-1:0] p);
        return (p == c_AW'(DEPTH - 1)) ? '0 : p + c_AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[r_wr]  <= r_tid[LAT];
            r_mem_err[r_wr] <= r_terr[LAT];
            r_mem_o[r_wr]   <= r_terr[LAT] ? '0 : sub_o;
            // A zero magnitude is always reported as positive.
            r_mem_sgn[r_wr] <= ~r_terr[LAT] & sub_sgn & (|sub_o);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= ptr_next(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_next(r_rd);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CW'(1);
                2'b01:   r_cnt <= r_cnt - c_CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Head fields read as zero while empty so the storage needs no reset.
    assign res_valid = (r_cnt != '0);
    assign res_id    = res_valid ? r_mem_id[r_rd]  : '0;
    assign res_o     = res_valid ? r_mem_o[r_rd]   : '0;
    assign res_sgn   = res_valid ? r_mem_sgn[r_rd] : 1'b0;
    assign res_err   = res_valid ? r_mem_err[r_rd] : 1'b0;

    // Both terms come straight from flops.
    assign busy = (|r_tv) | (r_cnt != '0);

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_cnt == c_CW'(DEPTH))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_sub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_sub_arbiter
// Purpose  : Self-checking bench for bcd_sub_arbiter with a behavioural
//            pipelined BCD subtract datapath, a reference arbiter/credit
//            model feeding a result scoreboard, a table of single-op vectors
//            and directed round-robin, backpressure, reset and digit-check
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_sub_arbiter;

    localparam int N     = 25;
    localparam int R     = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int W     = N * 4;
    localparam int IDW   = $clog2(R);
`ifdef BCDSUB_ARB_DIGCHK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [R-1:0]        req;
    logic [R-1:0][W-1:0] a_arr;
    logic [R-1:0][W-1:0] b_arr;
    logic [R-1:0]        gnt;
    logic [W-1:0]        sub_a, sub_b, sub_o, res_o;
    logic                sub_sgn, res_valid, res_ready, res_sgn, res_err, busy;
    logic [IDW-1:0]      res_id;

    bcd_sub_arbiter #(.N(N), .R(R), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .a_i(a_arr), .b_i(b_arr), .gnt(gnt),
        .sub_a(sub_a), .sub_b(sub_b), .sub_o(sub_o), .sub_sgn(sub_sgn),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_o(res_o), .res_sgn(res_sgn), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input logic [127:0] got, input logic [127:0] exp, input string what);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", what, got, exp);
        end
    endtask

    // ---------------- BCD helpers and datapath model ----------------
    function automatic logic [W-1:0] to_bcd(input longint unsigned v);
        logic [W-1:0] r = '0;
        for (int d = 0; d < N; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit bad_digit(input logic [W-1:0] v);
        for (int d = 0; d < N; d++) begin
            if (v[d*4 +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void raw_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] m, output bit borrow);
        int dig;
        borrow = 1'b0;
        m = '0;
        for (int d = 0; d < N; d++) begin
            dig = int'({28'd0, x[d*4 +: 4]}) - int'({28'd0, y[d*4 +: 4]}) - (borrow ? 1 : 0);
            borrow = (dig < 0);
            if (dig < 0) dig += 10;
            m[d*4 +: 4] = 4'(dig);
        end
    endfunction

    // {sign, magnitude}; equal operands come back as -0 so the DUT's
    // zero-sign clean-up is exercised.
    function automatic logic [W:0] dp_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] m;
        bit br;
        raw_sub(x, y, m, br);
        if (br || m == '0) begin
            raw_sub(y, x, m, br);
            return {1'b1, m};
        end
        return {1'b0, m};
    endfunction

    logic [W:0] dp_pipe [LAT];
    always @(posedge clk) begin
        dp_pipe[0] <= dp_sub(sub_a, sub_b);
        for (int j = 1; j < LAT; j++) dp_pipe[j] <= dp_pipe[j-1];
    end
    assign {sub_sgn, sub_o} = dp_pipe[LAT-1];

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   o;
        logic           sgn;
        logic           err;
    } res_t;

    res_t         sbq[$];
    res_t         m_exp;
    int           m_ptr = 0;
    int           m_out = 0;
    int           m_k;
    logic [R-1:0] m_eg;

    function automatic res_t expect_for(input int k);
        res_t r;
        logic [W:0] d;
        r.id = IDW'(k);
        if (EXP_ERR && (bad_digit(a_arr[k]) || bad_digit(b_arr[k]))) begin
            r.o = '0; r.sgn = 1'b0; r.err = 1'b1;
        end else begin
            d = dp_sub(a_arr[k], b_arr[k]);
            r.o = d[W-1:0]; r.sgn = d[W] && (d[W-1:0] != '0); r.err = 1'b0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            m_ptr = 0;
            m_out = 0;
            chk(gnt, 0, "reset gnt");
            chk(res_valid, 0, "reset res_valid");
            chk(busy, 0, "reset busy");
        end else begin
            m_eg = '0;
            m_k  = -1;
            if (m_out < DEPTH) begin
                for (int i = 0; i < R; i++) begin
                    if (m_k < 0 && req[(m_ptr + i) % R]) m_k = (m_ptr + i) % R;
                end
            end
            if (m_k >= 0) m_eg[m_k] = 1'b1;
            chk(gnt, m_eg, "model gnt");
            chk(busy, (m_out != 0), "model busy");
            if (res_valid && res_ready) begin
                if (sbq.size() == 0) begin
                    chk(res_o, 128'hDEAD, "spurious result");
                end else begin
                    m_exp = sbq.pop_front();
                    chk({res_id, res_o, res_sgn, res_err}, m_exp, "scoreboard result");
                end
                m_out--;
            end
            if (m_k >= 0) begin
                sbq.push_back(expect_for(m_k));
                m_ptr = (m_k + 1) % R;
                m_out++;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        int              id;
        longint unsigned a;
        longint unsigned b;
        longint unsigned o;
        bit              sgn;
    } vec_t;

    vec_t         tbl[5];
    logic [R-1:0] rr_exp[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy && sbq.size() == 0) break;
        end
        chk(busy, 0, "drain busy");
    endtask

    task automatic issue(input int k);
        req = R'(1) << k;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt[k]) break;
        end
        chk(gnt, R'(1) << k, "issue gnt");
        tick();
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat;
        bit found;
        rst = 1'b1; req = '0; a_arr = '0; b_arr = '0; res_ready = 1'b1;
        tbl[0] = '{0, 123, 45, 78, 1'b0};
        tbl[1] = '{2, 45, 123, 78, 1'b1};
        tbl[2] = '{1, 500, 500, 0, 1'b0};
        tbl[3] = '{3, 64'd999999999999999999, 1, 64'd999999999999999998, 1'b0};
        tbl[4] = '{0, 0, 1000000, 1000000, 1'b1};
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        @(negedge clk);
        chk(sub_a, 0, "reset sub_a");
        chk(sub_b, 0, "reset sub_b");
        chk({res_id, res_o, res_sgn, res_err}, 0, "reset head fields");
        tick();
        rst = 1'b0;

        // Single operations: grant, latency and result fields.
        foreach (tbl[v]) begin
            tick();
            a_arr[tbl[v].id] = to_bcd(tbl[v].a);
            b_arr[tbl[v].id] = to_bcd(tbl[v].b);
            req = R'(1) << tbl[v].id;
            @(negedge clk);
            chk(gnt, R'(1) << tbl[v].id, "tbl gnt");
            tick();
            req = '0;
            lat = 0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (res_valid) begin lat = c; break; end
            end
            chk(lat, LAT + 2, "tbl latency");
            chk(res_id, tbl[v].id, "tbl res_id");
            chk(res_o, to_bcd(tbl[v].o), "tbl res_o");
            chk(res_sgn, tbl[v].sgn, "tbl res_sgn");
            chk(res_err, 0, "tbl res_err");
        end
        drain();

        // Round robin from ptr=0.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        for (int k = 0; k < R; k++) begin
            a_arr[k] = to_bcd(longint'(100 + 7 * k));
            b_arr[k] = to_bcd(longint'(3 * k));
        end
        req = '1;
        n = 0;
        for (int c = 0; c < 30 && n < 5; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                chk(gnt, rr_exp[n], "rr gnt order");
                n++;
            end
        end
        chk(n, 5, "rr grant count");
        tick(); req = '0;
        drain();

        // Backpressure: credit stops issue at DEPTH outstanding.
        tick(); res_ready = 1'b0; req = 4'b0001;
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (gnt != '0) n++;
        end
        chk(n, DEPTH, "bp grant count");
        chk(gnt, 0, "bp stalled gnt");
        chk(busy, 1, "bp busy");
        tick(); res_ready = 1'b1;
        @(negedge clk);
        chk(gnt, 0, "bp pop-cycle gnt");
        tick(); res_ready = 1'b0;
        @(negedge clk);
        chk(gnt, 4'b0001, "bp regrant");
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (gnt != '0) n++;
        end
        chk(n, 0, "bp no extra grant");
        tick(); req = '0; res_ready = 1'b1;
        drain();

        // Reset with two operations in flight.
        tick(); req = '1;
        n = 0;
        for (int c = 0; c < 10 && n < 2; c++) begin
            @(negedge clk);
            if (gnt != '0) n++;
        end
        chk(n, 2, "rst pre grants");
        tick(); rst = 1'b1; req = '0;
        #1;
        chk(res_valid, 0, "rst immediate res_valid");
        chk(busy, 0, "rst immediate busy");
        tick(); rst = 1'b0; req = 4'b0110;
        @(negedge clk);
        chk(gnt, 4'b0010, "post-reset lowest gnt");
        tick(); req = '0;
        drain();

        // Invalid-digit operation between two valid ones.
        tick();
        a_arr[0] = to_bcd(5);   b_arr[0] = to_bcd(3);
        a_arr[1] = W'('h0F3);   b_arr[1] = W'('h001);
        a_arr[2] = to_bcd(7);   b_arr[2] = to_bcd(9);
        issue(0);
        issue(1);
        issue(2);
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (res_valid && res_id == IDW'(1)) begin
                found = 1'b1;
                chk(res_err, EXP_ERR, "digchk res_err");
                if (EXP_ERR) chk(res_o, 0, "digchk res_o");
                break;
            end
        end
        chk(found, 1, "digchk result seen");
        drain();
        chk(sbq.size(), 0, "scoreboard empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
